// File: rtl/signal_stability_detector.sv
// Comparator front end: synchronise and glitch-filter comp_in, measure its period,
// and flag lock once consecutive periods agree within TOL for STABLE_COUNT rises.
module signal_stability_detector #(
  parameter int unsigned CNT_WIDTH    = 24,
  parameter int unsigned FILTER_LEN   = 4,
  parameter int unsigned TOL          = 8,
  parameter int unsigned STABLE_COUNT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 comp_in,
  input  logic                 en,
  output logic                 sync_signal_out,
  output logic                 stable,
  output logic [CNT_WIDTH-1:0] period,
  output logic                 period_valid,
  output logic                 timeout
);

  localparam int unsigned RUN_W   = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int unsigned MATCH_W = $clog2(STABLE_COUNT + 1);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;
  localparam logic [RUN_W-1:0]     RUN_LAST   = RUN_W'(FILTER_LEN - 1);
  localparam logic [MATCH_W-1:0]   MATCH_LAST = MATCH_W'(STABLE_COUNT - 1);
  localparam logic [CNT_WIDTH:0]   TOL_EXT    = (CNT_WIDTH + 1)'(TOL);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2,
    LOCKED  = 2'd3
  } state_t;

  state_t               state;
  logic                 s1;
  logic                 s2;
  logic                 sync_d;
  logic [RUN_W-1:0]     run;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] ref_period;
  logic                 has_ref;
  logic [MATCH_W-1:0]   match_cnt;

  logic                 rise;
  logic                 cnt_sat;
  logic [CNT_WIDTH:0]   cnt_ext;
  logic [CNT_WIDTH:0]   ref_ext;
  logic [CNT_WIDTH:0]   diff;
  logic                 is_match;

  // Synchroniser plus run-length glitch filter; runs independently of en.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1              <= 1'b0;
      s2              <= 1'b0;
      sync_d          <= 1'b0;
      run             <= '0;
      sync_signal_out <= 1'b0;
    end else begin
      s1     <= comp_in;
      s2     <= s1;
      sync_d <= sync_signal_out;
      if (s2 == sync_signal_out) begin
        run <= '0;
      end else if (run == RUN_LAST) begin
        sync_signal_out <= s2;
        run             <= '0;
      end else begin
        run <= run + RUN_W'(1);
      end
    end
  end

  assign rise    = sync_signal_out & ~sync_d;
  assign cnt_sat = (cnt == CNT_MAX);
  assign cnt_ext = {1'b0, cnt};
  assign ref_ext = {1'b0, ref_period};

  // Absolute period difference; a saturated count never matches.
  always_comb begin
    diff     = '0;
    is_match = 1'b0;
    if (cnt_ext >= ref_ext) diff = cnt_ext - ref_ext;
    else                    diff = ref_ext - cnt_ext;
    is_match = (diff <= TOL_EXT) && !cnt_sat;
  end

  // Period counter and lock FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      ref_period   <= '0;
      has_ref      <= 1'b0;
      match_cnt    <= '0;
      stable       <= 1'b0;
      period       <= '0;
      period_valid <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      if (!en) begin
        state     <= IDLE;
        stable    <= 1'b0;
        cnt       <= '0;
        match_cnt <= '0;
        has_ref   <= 1'b0;
      end else begin
        if (rise)         cnt <= CNT_WIDTH'(1);
        else if (!cnt_sat) cnt <= cnt + CNT_WIDTH'(1);

        unique case (state)
          IDLE: begin
            cnt       <= '0;
            match_cnt <= '0;
            has_ref   <= 1'b0;
            stable    <= 1'b0;
            state     <= ARM;
          end
          ARM: begin
            if (rise) begin
              state     <= MEASURE;
              has_ref   <= 1'b0;
              match_cnt <= '0;
              timeout   <= 1'b0;
            end
          end
          MEASURE, LOCKED: begin
            if (rise) begin
              period       <= cnt;
              period_valid <= 1'b1;
              timeout      <= 1'b0;
              ref_period   <= cnt;
              if (!has_ref) begin
                has_ref   <= 1'b1;
                match_cnt <= '0;
              end else if (is_match) begin
                if (state == MEASURE) begin
                  match_cnt <= match_cnt + MATCH_W'(1);
                  if (match_cnt == MATCH_LAST) begin
                    state  <= LOCKED;
                    stable <= 1'b1;
                  end
                end
              end else begin
                match_cnt <= '0;
                state     <= MEASURE;
                stable    <= 1'b0;
              end
            end else if (cnt_sat) begin
              timeout <= 1'b1;
              stable  <= 1'b0;
              state   <= ARM;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_signal_stability_detector.sv
// Randomised bench for signal_stability_detector against a timestamp-based
// reference model; CNT_WIDTH is reduced so the timeout path is reachable.
module tb_signal_stability_detector;

  localparam int unsigned CNT_W = 10;
  localparam int unsigned FLEN  = 4;
  localparam int unsigned TOLV  = 8;
  localparam int unsigned SCNT  = 4;
  localparam int unsigned MAXP  = (1 << CNT_W) - 1;

  localparam int M_IDLE = 0;
  localparam int M_ARM  = 1;
  localparam int M_MEAS = 2;
  localparam int M_LOCK = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             comp_in = 1'b0;
  logic             en = 1'b0;
  logic             sync_signal_out;
  logic             stable;
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic             timeout;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  signal_stability_detector #(
    .CNT_WIDTH   (CNT_W),
    .FILTER_LEN  (FLEN),
    .TOL         (TOLV),
    .STABLE_COUNT(SCNT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .comp_in        (comp_in),
    .en             (en),
    .sync_signal_out(sync_signal_out),
    .stable         (stable),
    .period         (period),
    .period_valid   (period_valid),
    .timeout        (timeout)
  );

  // Reference model state: signal history plus rise timestamps.
  bit              m_s1, m_s2, m_sync, m_sync_d;
  bit              m_win[$];
  int              m_mode;
  bit              m_has_ref;
  int unsigned     m_ref;
  int unsigned     m_matches;
  longint unsigned m_now;
  longint unsigned m_last;
  bit              e_stable, e_pv, e_to;
  int unsigned     e_period;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_sync = 0; m_sync_d = 0;
    m_win.delete();
    m_mode = M_IDLE; m_has_ref = 0; m_ref = 0; m_matches = 0; m_last = 0;
    e_stable = 0; e_pv = 0; e_to = 0; e_period = 0;
  endtask

  // Advance the model by one clock using the inputs held during the cycle.
  task automatic model_clock();
    bit              rise_m;
    bit              flip;
    longint unsigned gap;
    int unsigned     d;
    bit              ok;
    if (rst) begin
      model_reset();
      m_now++;
      return;
    end
    rise_m = m_sync && !m_sync_d;
    // Output flips once the last FLEN synchronised samples all disagree with it.
    m_win.push_back(m_s2);
    if (m_win.size() > FLEN) void'(m_win.pop_front());
    flip = (m_win.size() == FLEN);
    foreach (m_win[i]) if (m_win[i] == m_sync) flip = 0;
    m_sync_d = m_sync;
    if (flip) m_sync = !m_sync;
    m_s2 = m_s1;
    m_s1 = comp_in;

    e_pv = 0;
    if (!en) begin
      m_mode = M_IDLE;
      e_stable = 0;
    end else if (m_mode == M_IDLE) begin
      m_mode = M_ARM;
    end else if (m_mode == M_ARM) begin
      if (rise_m) begin
        m_last = m_now; m_mode = M_MEAS; m_has_ref = 0; e_to = 0;
      end
    end else begin
      gap = m_now - m_last;
      if (gap > MAXP) gap = MAXP;
      if (rise_m) begin
        e_period = int'(gap); e_pv = 1; e_to = 0; m_last = m_now;
        if (!m_has_ref) begin
          m_has_ref = 1; m_ref = int'(gap); m_matches = 0;
        end else begin
          d  = (int'(gap) > m_ref) ? int'(gap) - m_ref : m_ref - int'(gap);
          ok = (d <= TOLV) && (gap != MAXP);
          m_ref = int'(gap);
          if (ok) begin
            if (m_mode == M_MEAS) begin
              m_matches++;
              if (m_matches == SCNT) begin m_mode = M_LOCK; e_stable = 1; end
            end
          end else begin
            m_matches = 0;
            m_mode = M_MEAS;
            e_stable = 0;
          end
        end
      end else if (gap == MAXP) begin
        e_to = 1; e_stable = 0; m_mode = M_ARM;
      end
    end
    m_now++;
  endtask

  task automatic cyc(input bit c);
    comp_in = c;
    @(posedge clk);
    model_clock();
    @(negedge clk);
    check("sync_signal_out", 32'(sync_signal_out), 32'(m_sync));
    check("stable",          32'(stable),          32'(e_stable));
    check("period",          32'(period),          e_period);
    check("period_valid",    32'(period_valid),    32'(e_pv));
    check("timeout",         32'(timeout),         32'(e_to));
  endtask

  task automatic hold(input bit v, input int n);
    for (int i = 0; i < n; i++) cyc(v);
  endtask

  task automatic wave(input int per, input int n);
    for (int k = 0; k < n; k++) begin
      hold(1'b1, per / 2);
      hold(1'b0, per - per / 2);
    end
  endtask

  task automatic jitter_wave(input int per, input int n, input int j);
    for (int k = 0; k < n; k++)
      wave(per + $urandom_range(0, 2 * j) - j, 1);
  endtask

  initial begin
    model_reset();
    m_now = 0;

    // Reset with a toggling input.
    rst = 1; en = 0;
    for (int i = 0; i < 3; i++) cyc(1'($urandom_range(0, 1)));
    check("reset_period", 32'(period), 32'd0);
    check("reset_stable", 32'(stable), 32'd0);
    rst = 0;
    hold(1'b0, 10);

    // Lock onto a clean period-100 square wave.
    en = 1;
    hold(1'b0, 3);
    wave(100, 8);
    check("lock100_stable", 32'(stable), 32'd1);
    check("lock100_period", 32'(period), 32'd100);

    // Glitch filter: 3-cycle, 4-cycle, then random short pulses.
    hold(1'b0, 60);
    hold(1'b1, 3); hold(1'b0, 30);
    hold(1'b1, 4); hold(1'b0, 30);
    for (int i = 0; i < 8; i++) begin
      hold(1'b1, $urandom_range(1, 7));
      hold(1'b0, $urandom_range(10, 40));
    end

    // Tolerance: relock at 100, one 108 period, then 120 breaks lock.
    wave(100, 8);
    wave(108, 1);
    check("tol108_stable", 32'(stable), 32'd1);
    wave(120, 1);
    hold(1'b1, 10);
    check("tol120_stable", 32'(stable), 32'd0);
    hold(1'b0, 50);
    wave(120, 6);
    check("relock120_stable", 32'(stable), 32'd1);

    // A gap of exactly the saturated count is reported as a period and breaks lock.
    hold(1'b1, 10); hold(1'b0, int'(MAXP) - 10);
    hold(1'b1, 10);
    check("sat_period", 32'(period), MAXP);
    check("sat_stable", 32'(stable), 32'd0);
    hold(1'b0, 50);

    // Timeout after lock, cleared by the next rise.
    wave(100, 8);
    hold(1'b0, 1100);
    check("timeout_set",    32'(timeout), 32'd1);
    check("timeout_stable", 32'(stable),  32'd0);
    wave(100, 1);
    check("timeout_clear",  32'(timeout), 32'd0);

    // Enable drop mid-lock, then relock taking six rises.
    wave(100, 8);
    en = 0;
    hold(1'b0, 1);
    check("en_low_stable", 32'(stable), 32'd0);
    hold(1'b0, 20);
    en = 1;
    hold(1'b0, 5);
    wave(100, 5);
    check("en_relock5", 32'(stable), 32'd0);
    wave(100, 2);
    check("en_relock6", 32'(stable), 32'd1);

    // Reset mid-lock clears period too.
    rst = 1;
    hold(1'b1, 1);
    check("rst_mid_period", 32'(period), 32'd0);
    check("rst_mid_stable", 32'(stable), 32'd0);
    rst = 0;
    hold(1'b0, 20);

    // Random segments: jittered waves, glitches, enable drops, rare resets.
    for (int s = 0; s < 30; s++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r == 0) begin
        en = 0;
        hold(1'($urandom_range(0, 1)), $urandom_range(1, 6));
        en = 1;
      end else if (r == 1) begin
        hold(1'b1, $urandom_range(1, 6));
        hold(1'b0, $urandom_range(8, 30));
      end else if (r == 2 && s % 10 == 5) begin
        rst = 1;
        hold(1'($urandom_range(0, 1)), $urandom_range(1, 3));
        rst = 0;
      end else begin
        jitter_wave($urandom_range(20, 200), $urandom_range(2, 8), $urandom_range(0, 10));
      end
    end
    hold(1'b0, 30);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
